// File: rtl/coolgirl_cfg_sequencer_if.sv
// CPU bus pins seen by the config sequencer: /ROMSEL, R/W, A14..A0, D7..D0.
// Master is the CPU side (testbench or pin pads); slave is the sequencer.
interface coolgirl_cfg_sequencer_if;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;

    modport master (output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in);
    modport slave  (input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in);
endinterface

// File: rtl/coolgirl_cfg_sequencer.sv
// Staged $5000-$5FFF mapping config with keyed atomic commit and mapper-reset pulse (optional CFG_READBACK_EN readback).
// Latency: key write edge to live update = COMMIT_DELAY+1 falling m2 edges, mapper_reset high on the edge after.
// Backpressure: none; writes arriving outside IDLE or after live lockout are silently dropped, cfg_busy flags COMMIT.
module coolgirl_cfg_sequencer #(
    parameter int unsigned COMMIT_DELAY = 4,
    parameter logic [7:0]  COMMIT_KEY   = 8'hA5
) (
    input  logic                            m2,
    input  logic                            reset_n,
    coolgirl_cfg_sequencer_if.slave         bus,
    output logic [12:0]                     cpu_base,
    output logic [4:0]                      cpu_mask,
    output logic [4:0]                      chr_mask,
    output logic [2:0]                      prg_mode,
    output logic [2:0]                      chr_mode,
    output logic [4:0]                      mapper,
    output logic [2:0]                      flags,
    output logic                            map_rom_on_6000,
    output logic [1:0]                      sram_page,
    output logic [1:0]                      mirroring,
    output logic                            sram_enabled,
    output logic                            chr_write_enabled,
    output logic                            prg_write_enabled,
    output logic                            lockout,
    output logic                            cfg_busy,
    output logic                            mapper_reset
`ifdef CFG_READBACK_EN
    ,
    output logic [7:0]                      cfg_rd_data,
    output logic                            cfg_rd_oe
`endif
);

    typedef enum logic [1:0] {IDLE, COMMIT, UPDATE, PULSE} state_t;

    localparam logic [3:0] LOAD = 4'(COMMIT_DELAY - 1);

    state_t     state;
    logic [3:0] counter;

    logic [4:0] stg_base_hi;
    logic [7:0] stg_base_lo;
    logic [4:0] stg_cpu_mask;
    logic [2:0] stg_prg_mode;
    logic [4:0] stg_chr_mask;
    logic [2:0] stg_chr_mode;
    logic [4:0] stg_mapper;
    logic [2:0] stg_flags;
    logic       stg_map_rom;
    logic [1:0] stg_sram_page;
    logic [1:0] stg_mirroring;
    logic       stg_lockout;
    logic       stg_prg_we;
    logic       stg_chr_we;
    logic       stg_sram_en;

    logic       cfg_sel;
    logic       cfg_wr;
    logic [2:0] idx;
    logic [7:0] d;
    logic       unused_addr;

    assign cfg_sel     = bus.romsel & (bus.cpu_addr_in[14:12] == 3'b101);
    assign cfg_wr      = cfg_sel & ~bus.cpu_rw_in & ~lockout & (state == IDLE);
    assign idx         = bus.cpu_addr_in[2:0];
    assign d           = bus.cpu_data_in;
    assign unused_addr = ^bus.cpu_addr_in[11:3];

    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            counter           <= 4'd0;
            cfg_busy          <= 1'b0;
            mapper_reset      <= 1'b0;
            stg_base_hi       <= '0;
            stg_base_lo       <= '0;
            stg_cpu_mask      <= '0;
            stg_prg_mode      <= '0;
            stg_chr_mask      <= '0;
            stg_chr_mode      <= '0;
            stg_mapper        <= '0;
            stg_flags         <= '0;
            stg_map_rom       <= 1'b0;
            stg_sram_page     <= '0;
            stg_mirroring     <= '0;
            stg_lockout       <= 1'b0;
            stg_prg_we        <= 1'b0;
            stg_chr_we        <= 1'b0;
            stg_sram_en       <= 1'b0;
            cpu_base          <= '0;
            cpu_mask          <= '0;
            chr_mask          <= '0;
            prg_mode          <= '0;
            chr_mode          <= '0;
            mapper            <= '0;
            flags             <= '0;
            map_rom_on_6000   <= 1'b0;
            sram_page         <= '0;
            mirroring         <= '0;
            sram_enabled      <= 1'b0;
            chr_write_enabled <= 1'b0;
            prg_write_enabled <= 1'b0;
            lockout           <= 1'b0;
        end else begin
            mapper_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_wr) begin
                        case (idx)
                            3'd0: stg_base_hi  <= d[4:0];
                            3'd1: stg_base_lo  <= d;
                            3'd2: stg_cpu_mask <= d[4:0];
                            3'd3: {stg_prg_mode, stg_chr_mask} <= d;
                            3'd4: {stg_chr_mode, stg_mapper} <= d;
                            3'd5: {stg_flags, stg_map_rom, stg_sram_page, stg_mirroring} <= d;
                            3'd6: begin
                                stg_lockout <= d[7];
                                stg_prg_we  <= d[3];
                                stg_chr_we  <= d[2];
                                stg_sram_en <= d[1];
                            end
                            3'd7: begin
                                // Wrong key is a no-op: no state change, no busy
                                if (d == COMMIT_KEY) begin
                                    state    <= COMMIT;
                                    counter  <= LOAD;
                                    cfg_busy <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                COMMIT: begin
                    if (counter == 4'd0) begin
                        state    <= UPDATE;
                        cfg_busy <= 1'b0;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                UPDATE: begin
                    cpu_base          <= {stg_base_hi, stg_base_lo};
                    cpu_mask          <= stg_cpu_mask;
                    chr_mask          <= stg_chr_mask;
                    prg_mode          <= stg_prg_mode;
                    chr_mode          <= stg_chr_mode;
                    mapper            <= stg_mapper;
                    flags             <= stg_flags;
                    map_rom_on_6000   <= stg_map_rom;
                    sram_page         <= stg_sram_page;
                    mirroring         <= stg_mirroring;
                    sram_enabled      <= stg_sram_en;
                    chr_write_enabled <= stg_chr_we;
                    prg_write_enabled <= stg_prg_we;
                    lockout           <= stg_lockout;
                    state             <= PULSE;
                end
                PULSE: begin
                    mapper_reset <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef CFG_READBACK_EN
    // Readback ignores lockout so software can still inspect a locked cart
    always_comb begin
        cfg_rd_oe   = cfg_sel & bus.cpu_rw_in & m2;
        cfg_rd_data = 8'h00;
        case (idx)
            3'd0: cfg_rd_data = {3'b000, stg_base_hi};
            3'd1: cfg_rd_data = stg_base_lo;
            3'd2: cfg_rd_data = {3'b000, stg_cpu_mask};
            3'd3: cfg_rd_data = {stg_prg_mode, stg_chr_mask};
            3'd4: cfg_rd_data = {stg_chr_mode, stg_mapper};
            3'd5: cfg_rd_data = {stg_flags, stg_map_rom, stg_sram_page, stg_mirroring};
            3'd6: cfg_rd_data = {stg_lockout, 3'b000, stg_prg_we, stg_chr_we, stg_sram_en, 1'b0};
            3'd7: cfg_rd_data = {cfg_busy, lockout, 6'b000000};
        endcase
    end
`endif

endmodule

// File: tb/tb_coolgirl_cfg_sequencer.sv
// Directed bench for coolgirl_cfg_sequencer: edge-scheduled behavioural model checked every falling m2 edge,
// plus hand-computed literal expectations; readback checks only when CFG_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_coolgirl_cfg_sequencer;
    localparam int         D   = 4;
    localparam logic [7:0] KEY = 8'hA5;

    logic m2      = 1'b0;
    logic reset_n = 1'b0;

    coolgirl_cfg_sequencer_if bus();

    logic [12:0] cpu_base;
    logic [4:0]  cpu_mask, chr_mask, mapper;
    logic [2:0]  prg_mode, chr_mode, flags;
    logic        map_rom_on_6000;
    logic [1:0]  sram_page, mirroring;
    logic        sram_enabled, chr_write_enabled, prg_write_enabled, lockout, cfg_busy, mapper_reset;
`ifdef CFG_READBACK_EN
    logic [7:0]  cfg_rd_data;
    logic        cfg_rd_oe;
`endif

    coolgirl_cfg_sequencer #(.COMMIT_DELAY(D), .COMMIT_KEY(KEY)) dut (
        .m2(m2), .reset_n(reset_n), .bus(bus),
        .cpu_base(cpu_base), .cpu_mask(cpu_mask), .chr_mask(chr_mask),
        .prg_mode(prg_mode), .chr_mode(chr_mode), .mapper(mapper), .flags(flags),
        .map_rom_on_6000(map_rom_on_6000), .sram_page(sram_page), .mirroring(mirroring),
        .sram_enabled(sram_enabled), .chr_write_enabled(chr_write_enabled),
        .prg_write_enabled(prg_write_enabled), .lockout(lockout),
        .cfg_busy(cfg_busy), .mapper_reset(mapper_reset)
`ifdef CFG_READBACK_EN
        , .cfg_rd_data(cfg_rd_data), .cfg_rd_oe(cfg_rd_oe)
`endif
    );

    always #5 m2 = ~m2;

    int checks = 0;
    int errors = 0;
    int mr_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: registers as byte images; a commit is a scheduled event keyed to the edge it was accepted on
    logic [7:0] stg[8];
    logic [7:0] live[8];
    int  edge_n = 0;
    int  key_edge = -100;
    bit  pend = 0;
    bit  exp_busy = 0;
    bit  exp_mr = 0;

    function automatic logic [7:0] reg_mask(input int i);
        case (i)
            0, 2:    return 8'h1F;
            6:       return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_step();
        bit acc, drop;
        int idx;
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                stg[i]  = 8'h00;
                live[i] = 8'h00;
            end
            pend = 0;
            exp_busy = 0;
            exp_mr = 0;
            return;
        end
        edge_n++;
        drop = pend && (edge_n > key_edge) && (edge_n <= key_edge + D + 2);
        acc  = bus.romsel && !bus.cpu_rw_in && (bus.cpu_addr_in[14:12] == 3'b101) && !live[6][7] && !drop;
        if (pend && edge_n == key_edge + D + 1)
            for (int i = 0; i < 7; i++) live[i] = stg[i];
        if (acc) begin
            idx = int'(bus.cpu_addr_in[2:0]);
            if (idx == 7) begin
                if (bus.cpu_data_in == KEY) begin
                    pend = 1;
                    key_edge = edge_n;
                end
            end else begin
                stg[idx] = bus.cpu_data_in & reg_mask(idx);
            end
        end
        exp_busy = pend && (edge_n >= key_edge) && (edge_n <= key_edge + D - 1);
        exp_mr   = pend && (edge_n == key_edge + D + 2);
    endtask

    function automatic logic [47:0] exp_vec();
        return {live[0][4:0], live[1], live[2][4:0], live[3][4:0], live[3][7:5],
                live[4][7:5], live[4][4:0], live[5][7:5], live[5][4], live[5][3:2], live[5][1:0],
                live[6][1], live[6][2], live[6][3], live[6][7], exp_busy, exp_mr};
    endfunction

    function automatic logic [47:0] act_vec();
        return {cpu_base, cpu_mask, chr_mask, prg_mode, chr_mode, mapper, flags, map_rom_on_6000,
                sram_page, mirroring, sram_enabled, chr_write_enabled, prg_write_enabled,
                lockout, cfg_busy, mapper_reset};
    endfunction

    always @(negedge m2) begin
        model_step();
        #1;
        check("cycle_outputs", {16'h0, act_vec()}, {16'h0, exp_vec()});
        if (mapper_reset) mr_count++;
    end

    task automatic bus_idle();
        bus.romsel      = 1'b0;
        bus.cpu_rw_in   = 1'b1;
        bus.cpu_addr_in = 15'h0000;
        bus.cpu_data_in = 8'h00;
    endtask

    // One bus cycle, presented across exactly one falling edge
    task automatic bus_op(input logic rs, input logic rw, input logic [14:0] a, input logic [7:0] dd);
        @(posedge m2); #1;
        bus.romsel = rs; bus.cpu_rw_in = rw; bus.cpu_addr_in = a; bus.cpu_data_in = dd;
        @(posedge m2); #1;
        bus_idle();
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] dd);
        bus_op(1'b1, 1'b0, 15'h5000 + 15'(idx), dd);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge m2);
        #2;
    endtask

    task automatic do_reset();
        @(posedge m2); #1 reset_n = 1'b0;
        repeat (2) @(posedge m2);
        #1 reset_n = 1'b1;
    endtask

`ifdef CFG_READBACK_EN
    task automatic rd_check(input logic [2:0] idx, input logic [7:0] lit, input string nm);
        logic [7:0] mexp;
        @(posedge m2); #1;
        bus.romsel = 1'b1; bus.cpu_rw_in = 1'b1; bus.cpu_addr_in = 15'h5000 + 15'(idx); bus.cpu_data_in = 8'h00;
        #1;
        mexp = (idx == 3'd7) ? {exp_busy, live[6][7], 6'b0} : stg[idx];
        check({nm, "_oe"}, {63'h0, cfg_rd_oe}, 64'h1);
        check({nm, "_model"}, {56'h0, cfg_rd_data}, {56'h0, mexp});
        check({nm, "_lit"}, {56'h0, cfg_rd_data}, {56'h0, lit});
        @(negedge m2); #2;
        check({nm, "_oe_m2low"}, {63'h0, cfg_rd_oe}, 64'h0);
        @(posedge m2); #1;
        bus_idle();
    endtask
`endif

    int mr_snap;

    initial begin
        bus_idle();
        repeat (2) @(negedge m2);
        @(posedge m2); #1 reset_n = 1'b1;
        check("rst_cpu_base", {51'h0, cpu_base}, 64'h0);
        check("rst_busy", {63'h0, cfg_busy}, 64'h0);
        check("rst_mapper_reset", {63'h0, mapper_reset}, 64'h0);

        // Basic commit latency
        mr_snap = mr_count;
        wr(3'd1, 8'h3C);
        wr(3'd7, KEY);
        wait_edges(4);
        check("base_before_update", {51'h0, cpu_base}, 64'h0);
        wait_edges(1);
        check("base_after_5", {51'h0, cpu_base}, 64'h3C);
        check("mr_edge5", {63'h0, mapper_reset}, 64'h0);
        wait_edges(1);
        check("mr_edge6", {63'h0, mapper_reset}, 64'h1);
        wait_edges(1);
        check("mr_edge7", {63'h0, mapper_reset}, 64'h0);
        check("mr_pulse_count", 64'(mr_count - mr_snap), 64'h1);

        // Accesses that must not touch staging
        bus_op(1'b1, 1'b0, 15'h4001, 8'hFF);
        bus_op(1'b1, 1'b0, 15'h6001, 8'hFF);
        bus_op(1'b0, 1'b0, 15'h5001, 8'hFF);
        bus_op(1'b1, 1'b1, 15'h5001, 8'hFF);
        wr(3'd7, 8'h12);
        wait_edges(1);
        check("wrong_key_not_busy", {63'h0, cfg_busy}, 64'h0);
        wr(3'd7, KEY);
        wait_edges(8);
        check("ignored_writes_base", {51'h0, cpu_base}, 64'h3C);

        // Staging invisible until commit
        wr(3'd4, 8'hE4);
        wait_edges(3);
        check("uncommitted_chr_mode", {61'h0, chr_mode}, 64'h0);
        check("uncommitted_mapper", {59'h0, mapper}, 64'h0);
        wr(3'd7, KEY);
        wait_edges(8);
        check("committed_chr_mode", {61'h0, chr_mode}, 64'h7);
        check("committed_mapper", {59'h0, mapper}, 64'h04);

        // Write during COMMIT dropped
        wr(3'd4, 8'h0A);
        wr(3'd7, KEY);
        wr(3'd4, 8'h01);
        wait_edges(8);
        check("drop_mapper", {59'h0, mapper}, 64'h0A);
        check("drop_chr_mode", {61'h0, chr_mode}, 64'h0);
        wr(3'd7, KEY);
        wait_edges(8);
        check("drop_staging_kept", {59'h0, mapper}, 64'h0A);

`ifdef CFG_READBACK_EN
        wr(3'd5, 8'h5A);
        rd_check(3'd5, 8'h5A, "rd_r5");
        rd_check(3'd7, 8'h00, "rd_r7_idle");
        wr(3'd7, KEY);
        rd_check(3'd7, 8'h80, "rd_r7_busy");
        wait_edges(8);
`endif

        // Lockout
        wr(3'd6, 8'h80);
        wr(3'd7, KEY);
        wait_edges(8);
        check("lockout_set", {63'h0, lockout}, 64'h1);
        mr_snap = mr_count;
        wr(3'd0, 8'h1F);
        wr(3'd7, KEY);
        wait_edges(8);
        check("locked_base_hi", {59'h0, cpu_base[12:8]}, 64'h0);
        check("locked_no_pulse", 64'(mr_count - mr_snap), 64'h0);
        check("locked_not_busy", {63'h0, cfg_busy}, 64'h0);
`ifdef CFG_READBACK_EN
        rd_check(3'd0, 8'h00, "rd_r0_locked");
        rd_check(3'd7, 8'h40, "rd_r7_locked");
`endif

        // Reset in the middle of COMMIT
        do_reset();
        check("reset_clears_lockout", {63'h0, lockout}, 64'h0);
        wr(3'd1, 8'h3C);
        wr(3'd7, KEY);
        repeat (2) @(negedge m2);
        #2 reset_n = 1'b0;
        #1;
        check("midcommit_busy", {63'h0, cfg_busy}, 64'h0);
        check("midcommit_outputs", {16'h0, act_vec()}, 64'h0);
        repeat (2) @(posedge m2);
        #1 reset_n = 1'b1;
        mr_snap = mr_count;
        wait_edges(10);
        check("midcommit_no_pulse", 64'(mr_count - mr_snap), 64'h0);
        check("midcommit_base", {51'h0, cpu_base}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
